// File: rtl/mips_pkg.sv
// Shared MIPS definitions: instruction encodings used by the core and the
// instruction memory controller state type.
package mips_pkg;

    localparam logic [31:0] NOP_WORD = 32'hFC000000;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        RUN   = 2'd1,
        LOAD  = 2'd2
    } imem_state_t;

endpackage

// File: rtl/imem_sync_if.sv
// Bus between the fetch/load/control side (master) and the instruction memory
// (slave): fetch handshake with stall, program load port and clear control.
interface imem_sync_if;

    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        fetch_ready;
    logic        stall;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_fault;

    logic        ld_mode;
    logic        ld_we;
    logic [31:0] ld_addr;
    logic [31:0] ld_data;
    logic        ld_err;

    logic        clr_req;
    logic        busy;

    modport master (
        output fetch_req, fetch_addr, stall,
        output ld_mode, ld_we, ld_addr, ld_data, clr_req,
        input  fetch_ready, instr, instr_valid, instr_fault, ld_err, busy
    );

    modport slave (
        input  fetch_req, fetch_addr, stall,
        input  ld_mode, ld_we, ld_addr, ld_data, clr_req,
        output fetch_ready, instr, instr_valid, instr_fault, ld_err, busy
    );

endinterface

// File: rtl/imem_ram.sv
// Single-port synchronous RAM, DEPTH x 32, registered read, no array reset.
module imem_ram #(
    parameter int unsigned DEPTH = 256,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/imem_sync.sv
// Loadable synchronous instruction memory: CLEAR/RUN/LOAD controller, NOP sweep,
// range/alignment checks and a stall-holding one-cycle fetch output.
module imem_sync
    import mips_pkg::imem_state_t;
    import mips_pkg::CLEAR;
    import mips_pkg::RUN;
    import mips_pkg::LOAD;
#(
    parameter int unsigned DEPTH    = 256,
    parameter logic [31:0] NOP_WORD = mips_pkg::NOP_WORD
) (
    input  logic      clk,
    input  logic      rst_n,
    imem_sync_if.slave bus
);

    localparam int unsigned AW = $clog2(DEPTH);

    imem_state_t   state, state_nxt;
    logic [AW-1:0] cnt, cnt_nxt;

    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_wdata;
    logic [31:0]   ram_rdata;

    logic [AW-1:0] fetch_idx, ld_idx;
    logic          fetch_in_range, fetch_aligned;
    logic          ld_ok;
    logic          hold, ready, accept;

    logic          valid_q, fault_q, fresh_q, nop_q, ld_err_q;
    logic [31:0]   instr_hold_q, instr_c;

    assign fetch_idx      = bus.fetch_addr[AW+1:2];
    assign fetch_in_range = (bus.fetch_addr[31:AW+2] == '0);
    assign fetch_aligned  = (bus.fetch_addr[1:0] == 2'b00);
    assign ld_idx         = bus.ld_addr[AW+1:2];
    assign ld_ok          = (bus.ld_addr[31:AW+2] == '0) && (bus.ld_addr[1:0] == 2'b00);

    // A cycle that leaves RUN never accepts, so an accepted fetch always
    // lands in a cycle where its result can actually be presented.
    assign hold   = valid_q && bus.stall;
    assign ready  = (state == RUN) && !hold && !bus.clr_req && !bus.ld_mode;
    assign accept = ready && bus.fetch_req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            CLEAR: begin
                cnt_nxt = cnt + 1'b1;
                if (cnt == AW'(DEPTH - 1)) begin
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                end
            end
            RUN: begin
                if (bus.clr_req) begin
                    state_nxt = CLEAR;
                    cnt_nxt   = '0;
                end else if (bus.ld_mode) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                if (bus.clr_req) begin
                    state_nxt = CLEAR;
                    cnt_nxt   = '0;
                end else if (!bus.ld_mode) begin
                    state_nxt = RUN;
                end
            end
            default: begin
                state_nxt = CLEAR;
                cnt_nxt   = '0;
            end
        endcase
    end

    // The FSM owns the single RAM port: sweep writes, load writes or fetch reads.
    always_comb begin
        ram_we    = 1'b0;
        ram_addr  = fetch_idx;
        ram_wdata = bus.ld_data;
        case (state)
            CLEAR: begin
                ram_we    = 1'b1;
                ram_addr  = cnt;
                ram_wdata = NOP_WORD;
            end
            LOAD: begin
                ram_addr = ld_idx;
                ram_we   = bus.ld_we && ld_ok && !bus.clr_req;
            end
            default: begin
                ram_we = 1'b0;
            end
        endcase
    end

    imem_ram #(
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q      <= 1'b0;
            fault_q      <= 1'b0;
            fresh_q      <= 1'b0;
            nop_q        <= 1'b0;
            ld_err_q     <= 1'b0;
            instr_hold_q <= NOP_WORD;
        end else begin
            fresh_q      <= accept;
            instr_hold_q <= instr_c;
            ld_err_q     <= (state == LOAD) && bus.ld_we && !ld_ok && !bus.clr_req;
            if (accept) begin
                valid_q <= 1'b1;
                fault_q <= !fetch_aligned;
                nop_q   <= !(fetch_aligned && fetch_in_range);
            end else if (hold && (state == RUN) && (state_nxt == RUN)) begin
                valid_q <= valid_q;
                fault_q <= fault_q;
            end else begin
                valid_q <= 1'b0;
                fault_q <= 1'b0;
            end
        end
    end

    // Fresh RAM data is shown only right after an accept; otherwise the last word is kept.
    assign instr_c = fresh_q ? (nop_q ? NOP_WORD : ram_rdata) : instr_hold_q;

    assign bus.fetch_ready = ready;
    assign bus.instr       = instr_c;
    assign bus.instr_valid = valid_q;
    assign bus.instr_fault = fault_q;
    assign bus.ld_err      = ld_err_q;
    assign bus.busy        = (state == CLEAR);

endmodule

// File: tb/tb_imem_sync.sv
// Directed self-checking bench for imem_sync at DEPTH=16: clear timing, load,
// fetch vectors, range/alignment faults, stall hold, load errors and restarts.
module tb_imem_sync;

    localparam logic [31:0] NOP = 32'hFC000000;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] exp_instr;
        logic        exp_fault;
    } fetch_vec_t;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    imem_sync_if bus();

    imem_sync #(
        .DEPTH    (16),
        .NOP_WORD (32'hFC000000)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    fetch_vec_t vecs[10];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic req, input logic [31:0] addr);
        bus.fetch_req  = req;
        bus.fetch_addr = addr;
        tick();
    endtask

    task automatic loadWrite(input logic [31:0] addr, input logic [31:0] data);
        bus.ld_we   = 1'b1;
        bus.ld_addr = addr;
        bus.ld_data = data;
        tick();
        bus.ld_we   = 1'b0;
    endtask

    task automatic countBusy(input string name);
        int n = 0;
        while (bus.busy === 1'b1 && n < 100) begin
            n++;
            tick();
        end
        checkOutput(name, 32'(n), 32'd16);
        checkOutput({name, "_ready_after"}, {31'b0, bus.fetch_ready}, 32'd1);
    endtask

    task automatic runVectors(input int first, input int last);
        for (int i = first; i <= last; i++) begin
            applyStimulus(1'b1, vecs[i].addr);
            checkOutput($sformatf("vec%0d_instr", i), bus.instr, vecs[i].exp_instr);
            checkOutput($sformatf("vec%0d_valid", i), {31'b0, bus.instr_valid}, 32'd1);
            checkOutput($sformatf("vec%0d_fault", i), {31'b0, bus.instr_fault}, {31'b0, vecs[i].exp_fault});
        end
        bus.fetch_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0] = '{32'h0000_0000, NOP,          1'b0};
        vecs[1] = '{32'h0000_0004, NOP,          1'b0};
        vecs[2] = '{32'h0000_003C, NOP,          1'b0};
        vecs[3] = '{32'h0000_0000, 32'h20100007, 1'b0};
        vecs[4] = '{32'h0000_0004, 32'hAC100081, 1'b0};
        vecs[5] = '{32'h0000_0008, 32'h8C130081, 1'b0};
        vecs[6] = '{32'h0000_000C, 32'h02641820, 1'b0};
        vecs[7] = '{32'h0000_0040, NOP,          1'b0};
        vecs[8] = '{32'h0000_0006, NOP,          1'b1};
        vecs[9] = '{32'h0000_003C, NOP,          1'b0};

        rst_n          = 1'b0;
        bus.fetch_req  = 1'b0;
        bus.fetch_addr = '0;
        bus.stall      = 1'b0;
        bus.ld_mode    = 1'b0;
        bus.ld_we      = 1'b0;
        bus.ld_addr    = '0;
        bus.ld_data    = '0;
        bus.clr_req    = 1'b0;

        #12;
        checkOutput("rst_instr", bus.instr, NOP);
        checkOutput("rst_valid", {31'b0, bus.instr_valid}, 32'd0);
        checkOutput("rst_fault", {31'b0, bus.instr_fault}, 32'd0);
        checkOutput("rst_ready", {31'b0, bus.fetch_ready}, 32'd0);
        checkOutput("rst_lderr", {31'b0, bus.ld_err}, 32'd0);
        checkOutput("rst_busy",  {31'b0, bus.busy}, 32'd1);

        @(negedge clk);
        rst_n = 1'b1;
        countBusy("clear_after_reset");

        runVectors(0, 2);

        // Program load of four instructions
        bus.ld_mode = 1'b1;
        tick();
        checkOutput("load_ready", {31'b0, bus.fetch_ready}, 32'd0);
        checkOutput("load_valid", {31'b0, bus.instr_valid}, 32'd0);
        checkOutput("load_busy",  {31'b0, bus.busy}, 32'd0);
        loadWrite(32'h0, 32'h20100007);
        loadWrite(32'h4, 32'hAC100081);
        loadWrite(32'h8, 32'h8C130081);
        loadWrite(32'hC, 32'h02641820);
        checkOutput("load_good_lderr", {31'b0, bus.ld_err}, 32'd0);
        bus.ld_mode = 1'b0;
        tick();

        runVectors(3, 9);

        // Stall hold with a queued request
        tick();
        checkOutput("idle_valid", {31'b0, bus.instr_valid}, 32'd0);
        applyStimulus(1'b1, 32'h4);
        checkOutput("stall_first_instr", bus.instr, 32'hAC100081);
        bus.stall      = 1'b1;
        bus.fetch_addr = 32'h8;
        #1;
        checkOutput("stall_ready_low", {31'b0, bus.fetch_ready}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput($sformatf("stall%0d_instr", i), bus.instr, 32'hAC100081);
            checkOutput($sformatf("stall%0d_valid", i), {31'b0, bus.instr_valid}, 32'd1);
            checkOutput($sformatf("stall%0d_ready", i), {31'b0, bus.fetch_ready}, 32'd0);
        end
        bus.stall = 1'b0;
        #1;
        checkOutput("unstall_ready", {31'b0, bus.fetch_ready}, 32'd1);
        tick();
        checkOutput("queued_instr", bus.instr, 32'h8C130081);
        checkOutput("queued_valid", {31'b0, bus.instr_valid}, 32'd1);
        bus.fetch_req = 1'b0;
        tick();
        checkOutput("after_idle_valid", {31'b0, bus.instr_valid}, 32'd0);
        checkOutput("after_idle_instr", bus.instr, 32'h8C130081);

        // Faulting load writes
        bus.ld_mode = 1'b1;
        tick();
        loadWrite(32'h40, 32'hDEADBEEF);
        checkOutput("lderr_range", {31'b0, bus.ld_err}, 32'd1);
        tick();
        checkOutput("lderr_range_pulse", {31'b0, bus.ld_err}, 32'd0);
        loadWrite(32'h2, 32'h12345678);
        checkOutput("lderr_align", {31'b0, bus.ld_err}, 32'd1);
        tick();
        checkOutput("lderr_align_pulse", {31'b0, bus.ld_err}, 32'd0);
        bus.ld_mode = 1'b0;
        tick();
        applyStimulus(1'b1, 32'h0);
        checkOutput("lderr_word0_kept", bus.instr, 32'h20100007);
        bus.fetch_req = 1'b0;

        // Clear requested from LOAD
        bus.ld_mode = 1'b1;
        tick();
        bus.clr_req = 1'b1;
        bus.ld_mode = 1'b0;
        tick();
        bus.clr_req = 1'b0;
        countBusy("clear_from_load");
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 32'(i * 4));
            checkOutput($sformatf("cleared_w%0d", i), bus.instr, NOP);
        end
        bus.fetch_req = 1'b0;

        // Reset in the middle of a sweep restarts it
        bus.ld_mode = 1'b1;
        tick();
        loadWrite(32'h0, 32'h11111111);
        bus.ld_mode = 1'b0;
        tick();
        bus.clr_req = 1'b1;
        tick();
        bus.clr_req = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_busy",  {31'b0, bus.busy}, 32'd1);
        checkOutput("midrst_instr", bus.instr, NOP);
        checkOutput("midrst_ready", {31'b0, bus.fetch_ready}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        countBusy("clear_after_midrst");
        applyStimulus(1'b1, 32'h0);
        checkOutput("midrst_word0", bus.instr, NOP);
        checkOutput("midrst_word0_valid", {31'b0, bus.instr_valid}, 32'd1);
        bus.fetch_req = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_sync.md
# imem_sync

Parametrised, synchronous, loadable instruction memory for the MIPS core; successor to the fixed combinational program ROM. It holds DEPTH 32-bit words and serves one-cycle-latency fetches through a request/valid handshake with stall hold. Program images are written at run time through a load port. A hardware clear sequencer fills every word with the NOP encoding after reset or on request. It sits between the fetch stage PC register and the decode stage.

## Interface
Parameters:
- DEPTH, 256: number of 32-bit words; power of two, minimum 4.
- NOP_WORD, 32'hFC000000: opcode 111111 filler returned for empty, out-of-range or faulting fetches.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- fetch_req  in  1  fetch request.
- fetch_addr  in  32  byte address of the instruction.
- fetch_ready  out  1  request is accepted this cycle.
- stall  in  1  decode cannot accept; hold the output word.
- instr  out  32  fetched instruction.
- instr_valid  out  1  instr is valid.
- instr_fault  out  1  fetch was misaligned (fetch_addr[1:0] != 0).
- ld_mode  in  1  request load mode.
- ld_we  in  1  load write strobe.
- ld_addr  in  32  byte address of the load write.
- ld_data  in  32  load write data.
- ld_err  out  1  one-cycle pulse: load write was out of range or misaligned.
- clr_req  in  1  one-cycle pulse that starts a full clear.
- busy  out  1  clear sweep is in progress.

## Operation
- FSM states are CLEAR, RUN and LOAD. Reset forces CLEAR with the sweep counter at 0.
- CLEAR:
  - Each cycle, write NOP_WORD to word[counter], then increment the counter.
  - When counter == DEPTH-1 has been written, go to RUN.
  - ld_we, clr_req and fetch_req are ignored. busy=1 and fetch_ready=0.
- RUN:
  - fetch_ready = !(instr_valid && stall).
  - An accepted fetch with word index fetch_addr>>2 < DEPTH and aligned address returns mem[index] next cycle.
  - An index ≥ DEPTH returns NOP_WORD with instr_fault=0.
  - A misaligned address returns NOP_WORD with instr_fault=1.
- LOAD:
  - fetch_ready=0 and instr_valid=0.
  - On ld_we, write ld_data to word ld_addr>>2.
  - If the index is ≥ DEPTH or ld_addr[1:0] != 0, drop the write and pulse ld_err the next cycle.
- Transition priority from RUN or LOAD: clr_req wins and goes to CLEAR with counter=0. Otherwise RUN→LOAD when ld_mode=1, and LOAD→RUN when ld_mode=0.
- Entering LOAD or CLEAR flushes the output: instr_valid=0 next cycle, and any held stalled word is discarded.
- Storage is a single port. Fetch reads and load/clear writes never overlap because the FSM keeps them mutually exclusive, so there is no read-during-write case.

## Timing
- Values while rst_n=0 and after release: instr=NOP_WORD, instr_valid=0, instr_fault=0, fetch_ready=0, ld_err=0, busy=1.
- The clear takes exactly DEPTH cycles. busy falls and fetch_ready rises in the cycle after the last word is written.
- Fetch latency is 1. A request accepted at edge N gives instr/instr_valid visible after edge N+1.
- Back-to-back requests sustain one word per cycle.
- If no fetch is accepted while not stalled, instr_valid=0 next cycle and instr keeps its last value.
- Stall: while instr_valid=1 and stall=1, instr, instr_valid and instr_fault hold, and no new request is accepted.
- A load write at edge N is readable by a fetch accepted at any edge after the return to RUN.
- ld_err is registered, one cycle after the offending ld_we.
- Reset asserted mid-clear or mid-load aborts immediately and restarts the clear. Memory contents are undefined until the sweep completes.

## Structure
- The shared package mips_pkg holds NOP_WORD, the opcode constants (OP_ADDI, OP_SW, OP_LW, OP_RTYPE, OP_BEQ, OP_J) and the imem_state_t enum {CLEAR, RUN, LOAD}.
- Sub-module imem_ram: a DEPTH×32 single-port synchronous RAM (we, addr[$clog2(DEPTH)-1:0], wdata, rdata) with no reset on the array.
- The FSM, sweep counter, range/alignment checks, output register and stall hold live in the top level.

## Test plan
- DEPTH=16, after reset: busy=1 for exactly 16 cycles, then fetch 0x0, 0x4 and 0x3C each return 0xFC000000 with valid=1 and fault=0.
- Load mode, then write 0x0→0x20100007, 0x4→0xAC100081, 0x8→0x8C130081, 0xC→0x02641820. Back in RUN, back-to-back fetches 0x0..0xC return these four words on four consecutive cycles.
- Fetch 0x40 (index 16) returns NOP with fault=0. Fetch 0x6 returns NOP with fault=1.
- Fetch 0x4 with stall=1 held 3 cycles: instr=0xAC100081 stays stable and fetch_ready=0. On release, the next queued fetch 0x8 completes 1 cycle later.
- In LOAD, ld_we to 0x40 and to 0x2: ld_err pulses once per write one cycle later, and memory is unchanged.
- clr_req while in LOAD: the FSM goes to CLEAR, busy=1 for 16 cycles, and all words read back 0xFC000000. Also assert rst_n=0 at sweep cycle 5: the clear restarts from word 0.
